// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: one rv32i ALU shared by two valid/ready requesters with 1-cycle registered responses
package alu_share_arbiter_pkg;
  typedef enum logic [4:0] {
    ALU_NOP  = 5'd0,
    ALU_ADD  = 5'd1,
    ALU_SUB  = 5'd2,
    ALU_SLL  = 5'd3,
    ALU_SLT  = 5'd4,
    ALU_SLTU = 5'd5,
    ALU_XOR  = 5'd6,
    ALU_SRL  = 5'd7,
    ALU_SRA  = 5'd8,
    ALU_OR   = 5'd9,
    ALU_AND  = 5'd10,
    ALU_BEQ  = 5'd11,
    ALU_BNE  = 5'd12,
    ALU_BLT  = 5'd13,
    ALU_BGE  = 5'd14,
    ALU_BLTU = 5'd15,
    ALU_BGEU = 5'd16,
    ALU_JALR = 5'd17
  } alu_op_e;
  typedef enum logic [1:0] {
    BRANCH_NONE     = 2'd0,
    BRANCH_RELATIVE = 2'd1,
    BRANCH_ABSOLUTE = 2'd2
  } branch_type_e;
endpackage

module alu_share_alu
  import alu_share_arbiter_pkg::*;
(
  input  alu_op_e      op_i,
  input  logic [31:0]  d1_i,
  input  logic [31:0]  d2_i,
  output logic [31:0]  result_o,
  output branch_type_e branch_o
);
  logic lt, ltu, eq;
  assign lt  = $signed(d1_i) < $signed(d2_i);
  assign ltu = d1_i < d2_i;
  assign eq  = d1_i == d2_i;
  always_comb begin
    result_o = '0;
    branch_o = BRANCH_NONE;
    case (op_i)
      ALU_ADD:  result_o = d1_i + d2_i;
      ALU_SUB:  result_o = d1_i - d2_i;
      ALU_SLL:  result_o = d1_i << d2_i[4:0];
      ALU_SLT:  result_o = {31'b0, lt};
      ALU_SLTU: result_o = {31'b0, ltu};
      ALU_XOR:  result_o = d1_i ^ d2_i;
      ALU_SRL:  result_o = d1_i >> d2_i[4:0];
      ALU_SRA:  result_o = $signed(d1_i) >>> d2_i[4:0];
      ALU_OR:   result_o = d1_i | d2_i;
      ALU_AND:  result_o = d1_i & d2_i;
      ALU_BEQ:  branch_o = eq   ? BRANCH_RELATIVE : BRANCH_NONE;
      ALU_BNE:  branch_o = !eq  ? BRANCH_RELATIVE : BRANCH_NONE;
      ALU_BLT:  branch_o = lt   ? BRANCH_RELATIVE : BRANCH_NONE;
      ALU_BGE:  branch_o = !lt  ? BRANCH_RELATIVE : BRANCH_NONE;
      ALU_BLTU: branch_o = ltu  ? BRANCH_RELATIVE : BRANCH_NONE;
      ALU_BGEU: branch_o = !ltu ? BRANCH_RELATIVE : BRANCH_NONE;
      ALU_JALR: begin
        result_o = (d1_i + d2_i) & ~32'd1;
        branch_o = BRANCH_ABSOLUTE;
      end
      default: ;
    endcase
  end
endmodule

module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [31:0]  req0_data1,
  input  logic [31:0]  req0_data2,
  input  alu_op_e      req0_op,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [31:0]  rsp0_result,
  output branch_type_e rsp0_branch,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [31:0]  req1_data1,
  input  logic [31:0]  req1_data2,
  input  alu_op_e      req1_op,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [31:0]  rsp1_result,
  output branch_type_e rsp1_branch,
  output logic         busy
);
  logic         elig0, elig1, grant0, grant1;
  logic         fav_q, fav_d;
  logic         rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [31:0]  rsp0_result_q, rsp0_result_d, rsp1_result_q, rsp1_result_d;
  branch_type_e rsp0_branch_q, rsp0_branch_d, rsp1_branch_q, rsp1_branch_d;
  alu_op_e      alu_op;
  logic [31:0]  alu_d1, alu_d2, alu_result;
  branch_type_e alu_branch;
  // a port may issue only if its response slot is empty or draining this cycle
  assign elig0  = req0_valid && (!rsp0_valid_q || rsp0_ready);
  assign elig1  = req1_valid && (!rsp1_valid_q || rsp1_ready);
  assign grant0 = !rst && elig0 && (!elig1 || FIXED_PRIORITY || !fav_q);
  assign grant1 = !rst && elig1 && !grant0;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign alu_op = grant0 ? req0_op    : grant1 ? req1_op    : ALU_NOP;
  assign alu_d1 = grant0 ? req0_data1 : grant1 ? req1_data1 : '0;
  assign alu_d2 = grant0 ? req0_data2 : grant1 ? req1_data2 : '0;
  alu_share_alu u_alu (
    .op_i     (alu_op),
    .d1_i     (alu_d1),
    .d2_i     (alu_d2),
    .result_o (alu_result),
    .branch_o (alu_branch)
  );
  assign fav_d         = grant0 ? 1'b1 : grant1 ? 1'b0 : fav_q;
  assign rsp0_valid_d  = grant0 || (rsp0_valid_q && !rsp0_ready);
  assign rsp1_valid_d  = grant1 || (rsp1_valid_q && !rsp1_ready);
  assign rsp0_result_d = grant0 ? alu_result : rsp0_result_q;
  assign rsp1_result_d = grant1 ? alu_result : rsp1_result_q;
  assign rsp0_branch_d = grant0 ? alu_branch : rsp0_branch_q;
  assign rsp1_branch_d = grant1 ? alu_branch : rsp1_branch_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      fav_q         <= 1'b0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
      rsp0_branch_q <= BRANCH_NONE;
      rsp1_branch_q <= BRANCH_NONE;
    end else begin
      fav_q         <= fav_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
      rsp0_branch_q <= rsp0_branch_d;
      rsp1_branch_q <= rsp1_branch_d;
    end
  end
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp0_branch = rsp0_branch_q;
  assign rsp1_branch = rsp1_branch_q;
  assign busy        = rsp0_valid_q || rsp1_valid_q;
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares a single rv32i ALU instance between two requesters: the core execute stage on port 0 and a secondary requester, such as a debug or loader engine, on port 1. Each port uses a valid/ready request channel and a valid/ready response channel. The arbiter selects one request per cycle, drives the internal ALU combinationally from the winner's operands, and registers the result into that port's response register. The block instantiates the ALU internally; there is no external ALU port.

Parameters:
FIXED_PRIORITY, 0, arbitration mode. 0 = round-robin between ports. 1 = port 0 always wins ties.

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_data1  in  32  port 0 operand 1
req0_data2  in  32  port 0 operand 2
req0_op  in  alu_op_e  port 0 ALU operation
rsp0_valid  out  1  port 0 response valid
rsp0_ready  in  1  port 0 response consumed
rsp0_result  out  32  port 0 registered ALU result
rsp0_branch  out  branch_type_e  port 0 registered branch decision
req1_valid / req1_ready / req1_data1 / req1_data2 / req1_op  same widths and meaning for port 1
rsp1_valid / rsp1_ready / rsp1_result / rsp1_branch  same widths and meaning for port 1
busy  out  1  OR of rsp0_valid and rsp1_valid

Behaviour:
- Reset (rst=1 at an edge):
  - rsp*_valid=0, rsp*_result=0, rsp*_branch=BRANCH_NONE, favour pointer=0.
  - req*_ready is forced to 0 combinationally while rst=1.
  - A pending response or an in-flight handshake in that cycle is discarded.
- Eligibility: elig_i = req_i_valid && (!rsp_i_valid || rsp_i_ready).
  - A port whose response is stalled cannot issue.
  - A port whose response is being consumed this cycle can issue back-to-back.
- Grant, combinational, at most one per cycle:
  - Only one port eligible: that port wins.
  - Both eligible and FIXED_PRIORITY=1: port 0 wins.
  - Both eligible and FIXED_PRIORITY=0: the port named by the favour pointer wins.
- req_i_ready = grant_i && !rst. The ready signal depends combinationally on the valids; requesters must not make valid depend on ready.
- ALU inputs are muxed from the granted port. With no grant they are zero operands with ALU_NOP.
- Handshake at edge N (req_i_valid && req_i_ready):
  - rsp_i_result and rsp_i_branch load the ALU outputs.
  - rsp_i_valid=1 from cycle N+1. Latency is exactly 1 cycle.
  - Favour pointer becomes 1-i. It updates only on a grant and is unused when FIXED_PRIORITY=1.
- Response hold: while rsp_i_valid && !rsp_i_ready, rsp_i_result and rsp_i_branch stay stable.
- Response retire: rsp_i_valid && rsp_i_ready with no new grant to port i → rsp_i_valid=0 next cycle. The data registers may hold stale values.
- Simultaneous retire and grant on the same port → rsp_i_valid stays 1 with the new data. This allows one op per cycle per port.
- The two ports' response registers are independent: port 1 is served while port 0 is stalled, and vice versa.
- Operation results follow the ALU contract:
  - Branch ops return result 0 plus a BRANCH_RELATIVE or BRANCH_NONE decision.
  - ALU_JALR returns (d1+d2)&~1 with BRANCH_ABSOLUTE.
  - ALU_NOP and undefined ops return result 0 with BRANCH_NONE; they still complete a handshake and produce a response.
- No request buffering: operands are sampled only at the handshake edge. Requesters hold data while valid && !ready.

Test Plan:
1. Port 0 alone, ALU_ADD d1=5 d2=7 → req0_ready=1 same cycle; next cycle rsp0_valid=1, rsp0_result=12, rsp0_branch=BRANCH_NONE; port 1 idle.
2. Both valid continuously, FIXED_PRIORITY=0, rsp*_ready=1 → grants alternate 0,1,0,1 starting with port 0 after reset; each port gets a response every other cycle.
3. Same as 2 with FIXED_PRIORITY=1 → port 0 granted every cycle; port 1 never granted until req0_valid drops, then granted the next cycle.
4. Backpressure: port 0 ALU_BLT d1=0xFFFFFFFF d2=1, rsp0_ready=0 for 3 cycles → rsp0_branch=BRANCH_RELATIVE held stable; req0_ready=0 for a new port 0 request; concurrent port 1 ALU_JALR d1=0x1001 d2=4 → rsp1_result=0x1004, rsp1_branch=BRANCH_ABSOLUTE. Raise rsp0_ready → the new port 0 request is accepted in that same cycle.
5. Back-to-back on port 0 with rsp0_ready=1: SUB 10-3, then SLL 1<<31 → rsp0_valid stays high for 2 consecutive cycles with results 7 then 0x80000000.
6. rst asserted with rsp1_valid=1 and req0_valid=1 → req*_ready=0 during reset; next cycle rsp*_valid=0, results 0, BRANCH_NONE; first grant after reset goes to port 0 when both ports request.
